// File: rtl/pikachu_motion_ctrl.sv
// Per-frame walk/jump/gravity sequencer and sprite-box decoder for the Pikachu renderer.
// Optional second mid-air jump is built when PIKACHU_DOUBLE_JUMP_EN is defined.
module pikachu_motion_ctrl #(
  parameter logic [9:0] START_X   = 10'd304,
  parameter logic [9:0] GROUND_Y  = 10'd400,
  parameter logic [9:0] X_MAX     = 10'd607,
  parameter logic [3:0] WALK_STEP = 4'd2,
  parameter logic [5:0] JUMP_V0   = 6'd10,
  parameter logic [3:0] ANIM_DIV  = 4'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       enable,
  output logic       par,
  output logic       airborne
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  localparam logic [6:0] VEL_JUMP = 7'd0 - {1'b0, JUMP_V0};
  localparam logic signed [6:0] VEL_MAX = 7'sd15;

  state_t            state_reg, state_next;
  logic [1:0]        left_sync, right_sync, jump_sync;
  logic              jump_prev_reg, jump_latch_reg;
  logic signed [6:0] vel_reg, vel_next, vel_inc;
  logic [9:0]        pos_x_reg, pos_x_next, pos_y_reg, pos_y_next;
  logic [3:0]        anim_cnt_reg, anim_cnt_next;
  logic              par_reg, par_next, airborne_reg;
  logic              left_s, right_s, jump_s, jump_edge, jump_req, anim_active, dj_fire;
  logic [11:0]       ny;
  logic [10:0]       x_sum;

  assign left_s    = left_sync[1];
  assign right_s   = right_sync[1];
  assign jump_s    = jump_sync[1];
  assign jump_edge = jump_s & ~jump_prev_reg;
  // An edge arriving in the tick cycle itself must still count for this tick.
  assign jump_req  = jump_latch_reg | jump_edge;

`ifdef PIKACHU_DOUBLE_JUMP_EN
  logic used_reg, used_next;
  assign dj_fire = jump_req & ~used_reg & (state_reg != GROUND);
`else
  assign dj_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_sync      <= 2'b00;
      right_sync     <= 2'b00;
      jump_sync      <= 2'b00;
      jump_prev_reg  <= 1'b0;
      jump_latch_reg <= 1'b0;
    end else begin
      left_sync      <= {left_sync[0], btn_left};
      right_sync     <= {right_sync[0], btn_right};
      jump_sync      <= {jump_sync[0], btn_jump};
      jump_prev_reg  <= jump_s;
      if (frame_tick)
        jump_latch_reg <= 1'b0;
      else if (jump_edge)
        jump_latch_reg <= 1'b1;
    end
  end

  // State register: every motion register advances only on frame_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= GROUND;
      vel_reg      <= 7'sd0;
      pos_x_reg    <= START_X;
      pos_y_reg    <= GROUND_Y;
      anim_cnt_reg <= 4'd0;
      par_reg      <= 1'b0;
      airborne_reg <= 1'b0;
`ifdef PIKACHU_DOUBLE_JUMP_EN
      used_reg     <= 1'b0;
`endif
    end else if (frame_tick) begin
      state_reg    <= state_next;
      vel_reg      <= vel_next;
      pos_x_reg    <= pos_x_next;
      pos_y_reg    <= pos_y_next;
      anim_cnt_reg <= anim_cnt_next;
      par_reg      <= par_next;
      airborne_reg <= (state_next != GROUND);
`ifdef PIKACHU_DOUBLE_JUMP_EN
      used_reg     <= used_next;
`endif
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_next = state_reg;
    vel_next   = vel_reg;
    pos_y_next = pos_y_reg;
    vel_inc    = vel_reg + 7'sd1;
    ny         = {2'b00, pos_y_reg} + {{5{vel_reg[6]}}, vel_reg};
    x_sum      = {1'b0, pos_x_reg} + {7'd0, WALK_STEP};

    case (state_reg)
      GROUND: begin
        if (jump_req) begin
          vel_next   = VEL_JUMP;
          state_next = RISE;
        end
      end
      RISE: begin
        if (dj_fire) begin
          vel_next = VEL_JUMP;
        end else if (ny[11]) begin
          pos_y_next = 10'd0;
          vel_next   = 7'sd0;
          state_next = FALL;
        end else begin
          pos_y_next = ny[9:0];
          vel_next   = vel_inc;
          if (!vel_inc[6])
            state_next = FALL;
        end
      end
      FALL: begin
        if (dj_fire) begin
          vel_next   = VEL_JUMP;
          state_next = RISE;
        end else if (!ny[11] && (ny[10:0] >= {1'b0, GROUND_Y})) begin
          pos_y_next = GROUND_Y;
          vel_next   = 7'sd0;
          state_next = GROUND;
        end else begin
          pos_y_next = ny[9:0];
          vel_next   = (vel_reg >= VEL_MAX) ? VEL_MAX : vel_inc;
        end
      end
      default: state_next = GROUND;
    endcase

    pos_x_next = pos_x_reg;
    if (left_s && !right_s)
      pos_x_next = (pos_x_reg >= {6'd0, WALK_STEP}) ? pos_x_reg - {6'd0, WALK_STEP} : 10'd0;
    else if (right_s && !left_s)
      pos_x_next = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];

    anim_active   = airborne_reg | (left_s ^ right_s);
    anim_cnt_next = 4'd0;
    par_next      = 1'b0;
    if (anim_active) begin
      if (anim_cnt_reg == ANIM_DIV - 4'd1) begin
        anim_cnt_next = 4'd0;
        par_next      = ~par_reg;
      end else begin
        anim_cnt_next = anim_cnt_reg + 4'd1;
        par_next      = par_reg;
      end
    end
  end

`ifdef PIKACHU_DOUBLE_JUMP_EN
  always_comb begin
    used_next = used_reg;
    if (dj_fire)
      used_next = 1'b1;
    else if (state_reg == FALL && state_next == GROUND)
      used_next = 1'b0;
  end
`endif

  // Outputs: 11-bit window compare so boxes near the screen edge never wrap.
  always_comb begin
    pos_x    = pos_x_reg;
    pos_y    = pos_y_reg;
    par      = par_reg;
    airborne = airborne_reg;
    enable   = ({1'b0, x} >= {1'b0, pos_x_reg} + 11'd1)  &&
               ({1'b0, x} <= {1'b0, pos_x_reg} + 11'd32) &&
               ({1'b0, y} >= {1'b0, pos_y_reg})          &&
               ({1'b0, y} <= {1'b0, pos_y_reg} + 11'd15);
  end

endmodule

// File: tb/tb_pikachu_motion_ctrl.sv
// Randomized self-checking bench for pikachu_motion_ctrl against a frame-level physics model.
module tb_pikachu_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [9:0] x = 10'd0, y = 10'd0;
  logic [9:0] pos_x, pos_y;
  logic       enable, par, airborne;

  pikachu_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .x(x), .y(y), .pos_x(pos_x), .pos_y(pos_y),
    .enable(enable), .par(par), .airborne(airborne)
  );

  always #5 clk = ~clk;

`ifdef PIKACHU_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int tick_no  = 0;

  // Model: sprite physics in plain integers.
  int m_px, m_py, m_vel, m_act;
  bit m_air, m_rise, m_used, m_par, m_pend;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, tick_no);
    end
  endtask

  task automatic model_reset();
    m_px = 304; m_py = 400; m_vel = 0; m_act = 0;
    m_air = 0; m_rise = 0; m_used = 0; m_par = 0; m_pend = 0;
  endtask

  task automatic model_step();
    int  ny;
    bit  active;
    active = m_air || (btn_left ^ btn_right);
    if (btn_left && !btn_right)      m_px = (m_px >= 2) ? m_px - 2 : 0;
    else if (btn_right && !btn_left) m_px = (m_px + 2 > 607) ? 607 : m_px + 2;

    if (!m_air) begin
      if (m_pend) begin
        m_air = 1; m_rise = 1; m_vel = -10;
      end
    end else if (DJ && m_pend && !m_used) begin
      m_rise = 1; m_vel = -10; m_used = 1;
    end else begin
      ny = m_py + m_vel;
      if (m_rise) begin
        m_vel = m_vel + 1;
        if (ny < 0) begin
          m_py = 0; m_vel = 0; m_rise = 0;
        end else begin
          m_py = ny;
          if (m_vel >= 0) m_rise = 0;
        end
      end else if (ny >= 400) begin
        m_py = 400; m_vel = 0; m_air = 0; m_used = 0;
      end else begin
        m_py = ny;
        m_vel = (m_vel + 1 > 15) ? 15 : m_vel + 1;
      end
    end

    if (active) begin
      m_act++;
      if (m_act % 6 == 0) m_par = !m_par;
    end else begin
      m_act = 0;
      m_par = 0;
    end
    m_pend = 0;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ".pos_x"}, int'(pos_x), m_px);
    check_val({tag, ".pos_y"}, int'(pos_y), m_py);
    check_val({tag, ".par"}, int'(par), int'(m_par));
    check_val({tag, ".airborne"}, int'(airborne), int'(m_air));
  endtask

  task automatic check_enable_at(input int xi, input int yi);
    int  exp;
    if (xi < 0) xi = 0;
    if (xi > 1023) xi = 1023;
    if (yi < 0) yi = 0;
    if (yi > 1023) yi = 1023;
    x = 10'(xi);
    y = 10'(yi);
    #1;
    exp = (xi >= m_px + 1 && xi <= m_px + 32 && yi >= m_py && yi <= m_py + 15) ? 1 : 0;
    check_val($sformatf("enable(%0d,%0d)", xi, yi), int'(enable), exp);
  endtask

  task automatic set_buttons(input bit l, input bit r, input bit j);
    if (j && !btn_jump) m_pend = 1;
    btn_left = l; btn_right = r; btn_jump = j;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_jump();
    set_buttons(btn_left, btn_right, 1'b1);
    btn_jump = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_tick(input string tag);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    tick_no++;
    model_step();
    $display("tick %0d %s: l=%0d r=%0d pos=(%0d,%0d) par=%0d air=%0d", tick_no, tag,
             btn_left, btn_right, pos_x, pos_y, par, airborne);
    check_state(tag);
  endtask

  int traj[22];

  initial begin
    traj = '{400, 390, 381, 373, 366, 360, 355, 351, 348, 346, 345,
             345, 346, 348, 351, 355, 360, 366, 373, 381, 390, 400};
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state("reset");

    // Idle frames and box decode around the resting sprite.
    repeat (3) do_tick("idle");
    check_enable_at(305, 400); check_enable_at(304, 400);
    check_enable_at(336, 415); check_enable_at(337, 415);
    check_enable_at(305, 399); check_enable_at(336, 416);

    // Walk right for 10 frames, then release.
    set_buttons(0, 1, 0);
    repeat (10) do_tick("walk_r");
    check_val("walk10.pos_x", int'(pos_x), 324);
    check_val("walk10.par", int'(par), 1);
    set_buttons(0, 0, 0);
    do_tick("release");
    check_val("release.par", int'(par), 0);

    // Saturate at the right edge, then walk to the left edge.
    set_buttons(0, 1, 0);
    for (int i = 0; i < 200 && m_px < 607; i++) do_tick("sat_r");
    do_tick("sat_r_hold");
    check_val("sat_r.pos_x", int'(pos_x), 607);
    set_buttons(1, 0, 0);
    for (int i = 0; i < 400 && m_px > 1; i++) do_tick("sat_l");
    check_val("near_left.pos_x", int'(pos_x), 1);
    do_tick("sat_l");
    check_val("left0.pos_x", int'(pos_x), 0);
    do_tick("sat_l");
    check_val("left0_hold.pos_x", int'(pos_x), 0);
    set_buttons(0, 0, 0);
    do_tick("stop");

    // Jump with the button held through landing: no re-trigger.
    set_buttons(0, 0, 1);
    for (int i = 0; i < 22; i++) begin
      do_tick("jump");
      check_val($sformatf("traj[%0d]", i), int'(pos_y), traj[i]);
      check_val($sformatf("traj_air[%0d]", i), int'(airborne), (i < 21) ? 1 : 0);
    end
    repeat (3) do_tick("held_landed");
    set_buttons(0, 0, 0);
    do_tick("jump_release");

    // Second edge during the fall.
    pulse_jump();
    repeat (13) do_tick("jump2");
    pulse_jump();
    for (int i = 0; i < 60 && m_air; i++) begin
      do_tick("second_edge");
      if (i == 4) pulse_jump();
    end
    repeat (2) do_tick("settle");

    // Asynchronous reset mid-jump.
    pulse_jump();
    repeat (6) do_tick("pre_reset");
    check_val("pre_reset.pos_y", int'(pos_y), 360);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("areset.pos_y", int'(pos_y), 400);
    check_val("areset.airborne", int'(airborne), 0);
    check_val("areset.par", int'(par), 0);
    check_val("areset.pos_x", int'(pos_x), 304);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_tick("post_reset");

    // Randomized frames.
    for (int i = 0; i < 120; i++) begin
      set_buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) pulse_jump();
      do_tick("rand");
      for (int k = 0; k < 3; k++)
        check_enable_at(m_px + $urandom_range(0, 34), m_py - 1 + $urandom_range(0, 17));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
